glcd_readback: RTL
==================

Name: glcd_readback

Overview:
- Read-side controller for the dual-chip (cs1/cs2) 128x64 KS0108-style graphic LCD driven by the display unit.
- Performs status reads and display-RAM reads: busy polling, page/Y address set, the mandatory dummy read, then the real read.
- Returns the byte to the game logic over a valid/ready request/response interface.
- Owns the LCD bus only while a request is active. The top level arbitrates it against the writer.

Parameters:
- PHASE_CYC, 8, clk cycles per bus phase (setup, E-high, hold); must be >=1.
- POLL_LIMIT, 255, max consecutive busy status reads before error; must be >=1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_type  in  1  0=status read, 1=display data read.
- req_cs  in  1  0=chip1 (cs1), 1=chip2 (cs2).
- req_page  in  3  X page 0-7 (data read only).
- req_col  in  6  Y column 0-63 (data read only).
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  8  status byte or display byte.
- rsp_err  out  1  busy-poll timeout.
- lcd_e, lcd_rs, lcd_rw  out  1 each  LCD strobe, register select, read/write.
- cs1, cs2  out  1 each  active-high chip selects.
- lcd_data_out  out  8  bus drive value.
- lcd_data_oe  out  1  bus drive enable.
- lcd_data_in  in  8  bus sample.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, lcd_e=0, lcd_rs=0, lcd_rw=1, cs1=0, cs2=0, lcd_data_out=0, lcd_data_oe=0.
- Reset mid-operation: abort at the next edge. Outputs go to reset values in that same cycle, with no trailing E pulse.
- Accept: req_valid&&req_ready at edge T. Fields are latched. req_ready drops. The first bus cycle starts at T+1.
- Bus cycle (3*PHASE_CYC clks):
  - SETUP: rs/rw/cs/data stable, lcd_e=0.
  - EHIGH: lcd_e=1. For reads, lcd_data_in is sampled on the last EHIGH clk.
  - HOLD: lcd_e=0, rs/rw/cs/data unchanged.
- The selected chip select is asserted for the whole cycle: cs1=~req_cs, cs2=req_cs.
- Writes: rw=0, oe=1 for all three phases. Reads: rw=1, oe=0.
- Bus cycle kinds:
  - STATUS: rs=0, rw=1.
  - SET_PAGE: rs=0, rw=0, data=8'hB8|page.
  - SET_Y: rs=0, rw=0, data=8'h40|col.
  - RD_DATA: rs=1, rw=1.
- FSM states: IDLE, POLL, SETPG, SETY, DUMMY, READ, RESP.
- POLL:
  - Performs a STATUS cycle. If sampled bit7=1 (busy), the poll counter increments and another STATUS cycle follows.
  - If bit7=0, the counter clears and the FSM goes to the stored return state.
  - If POLL_LIMIT busy reads occur in one POLL, go to RESP with rsp_err=1 and rsp_data=last status.
- Status request: a single STATUS cycle, no busy wait, then RESP. rsp_data=sampled byte, rsp_err=0.
- Data request sequence: POLL -> SETPG -> POLL -> SETY -> POLL -> DUMMY (RD_DATA, sample discarded) -> POLL -> READ (RD_DATA) -> RESP.
- Latency:
  - Status request: rsp_valid high from T+3*PHASE_CYC+1.
  - Data request with no busy: 8 bus cycles, rsp_valid from T+24*PHASE_CYC+1.
  - Each extra busy read adds 3*PHASE_CYC.
- RESP:
  - rsp_valid=1, bus idle: lcd_e=0, oe=0, cs1=cs2=0, rw=1.
  - On rsp_valid&&rsp_ready: rsp_valid drops and req_ready rises at the next edge. rsp_data/rsp_err hold until the next response.
  - A new request is not accepted in the same cycle as the response handshake.
- req_* changes after accept are ignored. req_valid while busy is not accepted.
- The column auto-increment side effect of reads is not compensated: after a data read, the chip's Y counter has advanced by 2 (dummy + real). The caller re-issues addresses.

Test Plan:
- PHASE_CYC=2, reset, then status request with req_cs=1; bus model returns 8'h20 -> cs2=1, cs1=0 during the cycle, lcd_e high at T+3..T+4, rsp_valid at T+7, rsp_data=8'h20, rsp_err=0.
- PHASE_CYC=2, data read page=5 col=17 on cs1, model never busy, RAM byte 8'hA5 -> writes observed 8'hBD then 8'h51 with oe=1 rw=0, two RD_DATA strobes (first ignored), rsp_valid at T+49, rsp_data=8'hA5.
- Same as the previous test, but the model reports busy (8'h80) for 3 status reads before SETY -> three extra STATUS cycles, rsp_valid at T+49+18=T+67, data correct.
- POLL_LIMIT=4, model permanently busy -> exactly 4 STATUS strobes, rsp_err=1, rsp_data=8'h80, no SET_PAGE write issued.
- Reset asserted mid-EHIGH of SETY -> next cycle lcd_e=0, oe=0, cs1=cs2=0, rw=1, req_ready=1, rsp_valid=0; a subsequent request completes normally.
- rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable, req_ready=0, lcd_e stays 0; rsp_ready pulse -> req_ready=1 next cycle.

Source files
------------

// File: rtl/glcd_readback_if.sv
// Request/response handshake between the game logic and the LCD readback controller.
// The requester drives req_* and rsp_ready; the controller drives req_ready and rsp_*.
// Both directions use plain valid/ready semantics.
interface glcd_readback_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_type;
  logic       req_cs;
  logic [2:0] req_page;
  logic [5:0] req_col;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_type, req_cs, req_page, req_col, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_type, req_cs, req_page, req_col, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/glcd_readback.sv
// Read-side controller for a dual-chip KS0108 128x64 LCD: status and display-RAM reads.
// Latency: status 3*PHASE_CYC+1 clks; data 24*PHASE_CYC+1 clks plus 3*PHASE_CYC per busy read.
// Backpressure: one request in flight; response held until rsp_ready, req_ready only in IDLE.
module glcd_readback #(
  parameter int PHASE_CYC  = 8,
  parameter int POLL_LIMIT = 255
) (
  input  logic           clk,
  input  logic           reset,
  glcd_readback_if.slave bus,
  output logic           lcd_e,
  output logic           lcd_rs,
  output logic           lcd_rw,
  output logic           cs1,
  output logic           cs2,
  output logic [7:0]     lcd_data_out,
  output logic           lcd_data_oe,
  input  logic [7:0]     lcd_data_in
);
  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, POLL, SETPG, SETY, DUMMY, READ, RESP} state_t;
  // PH_START is the single idle clock between accept and the first SETUP phase.
  typedef enum logic [1:0] {PH_START, PH_SETUP, PH_EHIGH, PH_HOLD} phase_t;

  state_t          state, state_n, ret, ret_n;
  phase_t          phase, phase_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [PW-1:0]   pcnt, pcnt_n;
  logic            phase_last;
  logic            accept, sample, load_rsp, err_n;

  logic            type_q, cs_q;
  logic [2:0]      page_q;
  logic [5:0]      col_q;
  logic [7:0]      samp, rsp_data_q;
  logic            rsp_err_q;

  logic            bus_cyc;
  logic            e_n, rs_n, rw_n, cs1_n, cs2_n, oe_n;
  logic [7:0]      dout_n;

  assign phase_last    = (cnt == CW'(PHASE_CYC - 1));
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  // FSM state register: reset aborts any bus cycle at the next edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ret   <= IDLE;
      phase <= PH_START;
      cnt   <= '0;
      pcnt  <= '0;
    end else begin
      state <= state_n;
      ret   <= ret_n;
      phase <= phase_n;
      cnt   <= cnt_n;
      pcnt  <= pcnt_n;
    end
  end

  // Next-state: phase sequencing within a bus cycle, sequencing between bus cycles
  always_comb begin
    state_n  = state;
    ret_n    = ret;
    phase_n  = phase;
    cnt_n    = cnt;
    pcnt_n   = pcnt;
    accept   = 1'b0;
    sample   = 1'b0;
    load_rsp = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_n = POLL;
          ret_n   = SETPG;
          phase_n = PH_START;
          cnt_n   = '0;
          pcnt_n  = '0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: begin
        case (phase)
          PH_START: begin
            phase_n = PH_SETUP;
            cnt_n   = '0;
          end
          PH_SETUP: begin
            if (phase_last) begin
              phase_n = PH_EHIGH;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          PH_EHIGH: begin
            sample = phase_last;
            if (phase_last) begin
              phase_n = PH_HOLD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          default: begin
            if (!phase_last) begin
              cnt_n = cnt + CW'(1);
            end else begin
              // End of a bus cycle: the next one starts with SETUP immediately.
              cnt_n   = '0;
              phase_n = PH_SETUP;
              case (state)
                POLL: begin
                  if (!type_q) begin
                    state_n  = RESP;
                    load_rsp = 1'b1;
                  end else if (!samp[7]) begin
                    pcnt_n  = '0;
                    state_n = ret;
                  end else if (pcnt == PW'(POLL_LIMIT - 1)) begin
                    state_n  = RESP;
                    load_rsp = 1'b1;
                    err_n    = 1'b1;
                  end else begin
                    pcnt_n = pcnt + PW'(1);
                  end
                end
                SETPG: begin
                  state_n = POLL;
                  ret_n   = SETY;
                end
                SETY: begin
                  state_n = POLL;
                  ret_n   = DUMMY;
                end
                DUMMY: begin
                  state_n = POLL;
                  ret_n   = READ;
                end
                READ: begin
                  state_n  = RESP;
                  load_rsp = 1'b1;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  // Request fields, bus sample and the held response
  always_ff @(posedge clk) begin
    if (reset) begin
      type_q     <= 1'b0;
      cs_q       <= 1'b0;
      page_q     <= '0;
      col_q      <= '0;
      samp       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        type_q <= bus.req_type;
        cs_q   <= bus.req_cs;
        page_q <= bus.req_page;
        col_q  <= bus.req_col;
      end
      if (sample) samp <= lcd_data_in;
      if (load_rsp) begin
        rsp_data_q <= samp;
        rsp_err_q  <= err_n;
      end
    end
  end

  // LCD pin values for the upcoming state, so the pins come straight from flops
  always_comb begin
    e_n     = 1'b0;
    rs_n    = 1'b0;
    rw_n    = 1'b1;
    cs1_n   = 1'b0;
    cs2_n   = 1'b0;
    oe_n    = 1'b0;
    dout_n  = 8'h00;
    bus_cyc = (phase_n != PH_START) && (state_n != IDLE) && (state_n != RESP);
    if (bus_cyc) begin
      cs1_n = ~cs_q;
      cs2_n = cs_q;
      e_n   = (phase_n == PH_EHIGH);
      case (state_n)
        SETPG: begin
          rw_n   = 1'b0;
          oe_n   = 1'b1;
          dout_n = 8'hB8 | {5'd0, page_q};
        end
        SETY: begin
          rw_n   = 1'b0;
          oe_n   = 1'b1;
          dout_n = 8'h40 | {2'd0, col_q};
        end
        DUMMY, READ: rs_n = 1'b1;
        default: ;
      endcase
    end
  end

  // LCD pin registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lcd_e        <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_rw       <= 1'b1;
      cs1          <= 1'b0;
      cs2          <= 1'b0;
      lcd_data_out <= 8'h00;
      lcd_data_oe  <= 1'b0;
    end else begin
      lcd_e        <= e_n;
      lcd_rs       <= rs_n;
      lcd_rw       <= rw_n;
      cs1          <= cs1_n;
      cs2          <= cs2_n;
      lcd_data_out <= dout_n;
      lcd_data_oe  <= oe_n;
    end
  end
endmodule
